irq_arbiter: RTL and testbench



---
 rtl/irq_arbiter_pkg.sv | 18 +
 rtl/irq_arbiter_prio_enc.sv | 17 +
 rtl/irq_arbiter.sv | 123 ++++++++++++
 tb/tb_irq_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the interrupt arbiter.
package irq_arbiter_pkg;

   localparam int IRQ_SOURCES  = 8;
   localparam int IRQ_NONE_BIT = 3;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_PRESENT = 2'd1,
      IRQ_GAP     = 2'd2
   } irq_state_t;

   // One-hot pending bit for a presented source index.
   function automatic logic [IRQ_SOURCES-1:0] irq_onehot(input logic [2:0] idx);
      irq_onehot = 8'd1 << idx;
   endfunction

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Priority encoder: highest set bit wins; index[3] flags an empty input vector.
module irq_arbiter_prio_enc
   import irq_arbiter_pkg::*;
(
   input  logic [IRQ_SOURCES-1:0] bits,
   output logic [3:0]             index
);

   // Ascending scan so the last (highest) set bit overrides lower ones.
   always_comb begin
      index = 4'b1000;
      for (int i = 0; i < IRQ_SOURCES; i++) begin
         index = bits[i] ? {1'b0, 3'(i)} : index;
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt front end: synchronise and edge-detect eight requests, latch them as
// pending, mask, and present the highest-priority source to the host with req/ack.
module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int                     SYNC_STAGES = 2,
   parameter logic [IRQ_SOURCES-1:0] MASK_RESET  = 8'h00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IRQ_SOURCES-1:0] irqIn,
   input  logic                   maskWr,
   input  logic [IRQ_SOURCES-1:0] maskData,
   input  logic                   clrWr,
   input  logic [IRQ_SOURCES-1:0] clrData,
   input  logic                   ack,
   output logic                   irqOut,
   output logic [2:0]             irqIndex,
   output logic [IRQ_SOURCES-1:0] pending,
   output logic [IRQ_SOURCES-1:0] mask
);

   logic [SYNC_STAGES-1:0][IRQ_SOURCES-1:0] sync_q, sync_d;
   logic [IRQ_SOURCES-1:0] prev_q, prev_d;
   logic [IRQ_SOURCES-1:0] pending_q, pending_d;
   logic [IRQ_SOURCES-1:0] mask_q, mask_d;
   logic                   irq_out_q, irq_out_d;
   logic [2:0]             irq_index_q, irq_index_d;
   irq_state_t             state_q, state_d;

   logic [IRQ_SOURCES-1:0] rise_s;
   logic [IRQ_SOURCES-1:0] masked_s;
   logic [IRQ_SOURCES-1:0] clr_vec_s;
   logic [3:0]             enc_index_s;
   logic                   ack_ok_s;

   irq_arbiter_prio_enc u_prio_enc (
      .bits  (masked_s),
      .index (enc_index_s)
   );

   // Synchroniser chain, edge detector, mask and pending update.
   always_comb begin
      sync_d[0] = irqIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      prev_d    = sync_q[SYNC_STAGES-1];
      rise_s    = sync_q[SYNC_STAGES-1] & ~prev_q;
      masked_s  = pending_q & mask_q;
      clr_vec_s = (clrWr ? clrData : 8'h00) |
                  (ack_ok_s ? irq_onehot(irq_index_q) : 8'h00);
      // Set is OR-ed after the clear so a coincident edge is never lost.
      pending_d = (pending_q & ~clr_vec_s) | rise_s;
      mask_d    = maskWr ? maskData : mask_q;
   end

   // Presentation state machine; the index is frozen outside IDLE.
   always_comb begin
      state_d     = state_q;
      irq_out_d   = irq_out_q;
      irq_index_d = irq_index_q;
      ack_ok_s    = 1'b0;
      case (state_q)
         IRQ_IDLE: begin
            if (!enc_index_s[IRQ_NONE_BIT]) begin
               irq_index_d = enc_index_s[2:0];
               irq_out_d   = 1'b1;
               state_d     = IRQ_PRESENT;
            end else begin
               irq_out_d   = 1'b0;
            end
         end
         IRQ_PRESENT: begin
            if (ack) begin
               ack_ok_s  = 1'b1;
               irq_out_d = 1'b0;
               state_d   = IRQ_GAP;
            end else if (!masked_s[irq_index_q]) begin
               irq_out_d = 1'b0;
               state_d   = IRQ_GAP;
            end else begin
               irq_out_d = 1'b1;
            end
         end
         IRQ_GAP: begin
            irq_out_d = 1'b0;
            state_d   = IRQ_IDLE;
         end
         default: begin
            irq_out_d = 1'b0;
            state_d   = IRQ_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '0;
         prev_q      <= 8'h00;
         pending_q   <= 8'h00;
         mask_q      <= MASK_RESET;
         irq_out_q   <= 1'b0;
         irq_index_q <= 3'd0;
         state_q     <= IRQ_IDLE;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         irq_out_q   <= irq_out_d;
         irq_index_q <= irq_index_d;
         state_q     <= state_d;
      end
   end

   assign irqOut   = irq_out_q;
   assign irqIndex = irq_index_q;
   assign pending  = pending_q;
   assign mask     = mask_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios then random traffic, all compared
// cycle by cycle against a sample-history reference model.
module tb_irq_arbiter;

   localparam int         SYNC  = 2;
   localparam logic [7:0] MRST  = 8'h00;

   logic       clk;
   logic       rst;
   logic [7:0] irqIn;
   logic       maskWr;
   logic [7:0] maskData;
   logic       clrWr;
   logic [7:0] clrData;
   logic       ack;
   logic       irqOut;
   logic [2:0] irqIndex;
   logic [7:0] pending;
   logic [7:0] mask;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] m_hist [0:SYNC];
   logic [7:0] m_pend;
   logic [7:0] m_mask;
   logic [2:0] m_idx;
   int         m_phase;   // 0 waiting, 1 presenting, 2 forced low cycle

   irq_arbiter #(.SYNC_STAGES(SYNC), .MASK_RESET(MRST)) dut (
      .clk      (clk),
      .rst      (rst),
      .irqIn    (irqIn),
      .maskWr   (maskWr),
      .maskData (maskData),
      .clrWr    (clrWr),
      .clrData  (clrData),
      .ack      (ack),
      .irqOut   (irqOut),
      .irqIndex (irqIndex),
      .pending  (pending),
      .mask     (mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [7:0] rise, clr, elig;
      if (rst) begin
         m_pend  = 8'h00;
         m_mask  = MRST;
         m_idx   = 3'd0;
         m_phase = 0;
         for (int k = 0; k <= SYNC; k++) m_hist[k] = 8'h00;
      end else begin
         rise = m_hist[SYNC-1] & ~m_hist[SYNC];
         elig = m_pend & m_mask;
         clr  = clrWr ? clrData : 8'h00;
         if (m_phase == 0) begin
            if (elig != 8'h00) begin
               for (int b = 0; b < 8; b++) if (elig[b]) m_idx = 3'(b);
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (ack) begin
               clr[m_idx] = 1'b1;
               m_phase = 2;
            end else if (!elig[m_idx]) begin
               m_phase = 2;
            end
         end else begin
            m_phase = 0;
         end
         m_pend = (m_pend & ~clr) | rise;
         if (maskWr) m_mask = maskData;
         for (int k = SYNC; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = irqIn;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_val("irqOut",   {7'd0, irqOut},   {7'd0, (m_phase == 1)});
      check_val("irqIndex", {5'd0, irqIndex}, {5'd0, m_idx});
      check_val("pending",  pending,          m_pend);
      check_val("mask",     mask,             m_mask);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; irqIn = 8'h00; maskWr = 1'b0; maskData = 8'h00;
      clrWr = 1'b0; clrData = 8'h00; ack = 1'b0;
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      irqIn = v; tick(); irqIn = 8'h00;
   endtask

   task automatic write_mask(input logic [7:0] v);
      maskWr = 1'b1; maskData = v; tick(); maskWr = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      check_val("rst_irqOut", {7'd0, irqOut}, 8'd0);
      check_val("rst_pending", pending, 8'h00);
      check_val("rst_mask", mask, MRST);
      rst = 1'b0;

      // Single source, three-cycle latency, ack then gap
      write_mask(8'hFF);
      pulse_irq(8'h20);
      tick(); tick();
      check_val("lat_early", {7'd0, irqOut}, 8'd0);
      tick();
      check_val("t1_out", {7'd0, irqOut}, 8'd1);
      check_val("t1_idx", {5'd0, irqIndex}, 8'd5);
      do_ack();
      check_val("t1_pend", pending, 8'h00);
      tick();
      check_val("t1_gap", {7'd0, irqOut}, 8'd0);

      // Two simultaneous sources: 7 then 0
      pulse_irq(8'h81);
      tick(); tick(); tick();
      check_val("t2_idx7", {5'd0, irqIndex}, 8'd7);
      do_ack(); tick(); tick();
      check_val("t2_idx0", {5'd0, irqIndex}, 8'd0);
      check_val("t2_out", {7'd0, irqOut}, 8'd1);
      do_ack();
      check_val("t2_pend", pending, 8'h00);
      tick();

      // Mask off a presented source, then re-enable
      pulse_irq(8'h08);
      tick(); tick(); tick();
      check_val("t3_idx", {5'd0, irqIndex}, 8'd3);
      write_mask(8'hF7);
      tick();
      check_val("t3_drop", {7'd0, irqOut}, 8'd0);
      check_val("t3_pend", pending, 8'h08);
      tick();
      write_mask(8'hFF);
      tick();
      check_val("t3_repres", {7'd0, irqOut}, 8'd1);
      check_val("t3_idx2", {5'd0, irqIndex}, 8'd3);
      do_ack(); tick();

      // Ack coincides with a new rise on the same bit
      pulse_irq(8'h04);
      tick(); tick(); tick();
      check_val("t4_idx", {5'd0, irqIndex}, 8'd2);
      pulse_irq(8'h04);
      tick();
      do_ack();
      check_val("t4_pend", pending, 8'h04);
      tick(); tick();
      check_val("t4_repres", {7'd0, irqOut}, 8'd1);
      check_val("t4_idx2", {5'd0, irqIndex}, 8'd2);
      do_ack(); tick();

      // Software clear retracts; spurious ack in idle does nothing
      pulse_irq(8'h40);
      tick(); tick(); tick();
      check_val("t5_idx", {5'd0, irqIndex}, 8'd6);
      clrWr = 1'b1; clrData = 8'hFF; tick(); clrWr = 1'b0; clrData = 8'h00;
      check_val("t5_pend", pending, 8'h00);
      tick();
      check_val("t5_drop", {7'd0, irqOut}, 8'd0);
      tick(); tick();
      do_ack();
      check_val("t5_spur", {7'd0, irqOut}, 8'd0);
      tick();

      // Reset mid-handshake
      pulse_irq(8'h02);
      tick(); tick(); tick();
      check_val("t6_pres", {7'd0, irqOut}, 8'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check_val("t6_out", {7'd0, irqOut}, 8'd0);
      check_val("t6_pend", pending, 8'h00);
      check_val("t6_mask", mask, MRST);
      write_mask(8'hFF);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) irqIn = 8'($urandom);
         maskWr   = ($urandom_range(0, 15) == 0);
         maskData = 8'($urandom) | 8'h0F;
         clrWr    = ($urandom_range(0, 19) == 0);
         clrData  = 8'($urandom);
         ack      = (m_phase == 1) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 9) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
